// File: rtl/edge_detect_mc.sv
// -----------------------------------------------------------------------------
// edge_detect_mc
//
// Multi-channel edge detector. Each asynchronous din bit is synchronised,
// then passed through a persistence filter. The filter accepts a new level only
// after the synchronised input has differed from the accepted level for FILT
// consecutive cycles. Accepted transitions produce registered one-cycle pulses.
// A mode-gated event output drives a sticky flag and, optionally, a saturating
// event counter for each channel.
//
// Build option:
//   EDGE_CNT_EN  defined   -> each channel has a CNT_W-bit saturating counter
//                undefined -> no counters are built and cnt is tied to 0
//
// Parameters:
//   CH     number of independent channels (1..32)
//   SYNC   synchroniser stages per channel (2..4)
//   FILT   cycles a new level must persist before it is accepted (1..255)
//   CNT_W  width of each event counter (2..16)
//
// Ports:
//   clk       single clock, rising edge
//   rst       synchronous reset, active high
//   din       asynchronous level inputs, one bit per channel
//   mode      event select: 00 none, 01 rising, 10 falling, 11 both
//   clr       per-channel clear for the sticky flag and counter
//   pos_edge  one-cycle pulse for each accepted rising transition
//   neg_edge  one-cycle pulse for each accepted falling transition
//   evt       pos_edge/neg_edge gated by mode (combinational)
//   flag      sticky event indicator
//   cnt       event counters, channel i at [i*CNT_W +: CNT_W]
// -----------------------------------------------------------------------------
module edge_detect_mc #(
    parameter int CH    = 4,
    parameter int SYNC  = 2,
    parameter int FILT  = 3,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       din,
    input  logic [1:0]          mode,
    input  logic [CH-1:0]       clr,
    output logic [CH-1:0]       pos_edge,
    output logic [CH-1:0]       neg_edge,
    output logic [CH-1:0]       evt,
    output logic [CH-1:0]       flag,
    output logic [CH*CNT_W-1:0] cnt
);

    localparam int FC_W = (FILT < 2) ? 1 : $clog2(FILT + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILT - 1);

    for (genvar i = 0; i < CH; i++) begin : g_ch

        logic [SYNC-1:0] sync_q;
        logic            sync_lvl;
        logic            lvl;
        logic            lvl_d;
        logic [FC_W-1:0] fc;
        logic            pos_q;
        logic            neg_q;
        logic            evt_c;
        logic            flag_q;

        // Plain shift chain: nothing may sit between synchroniser stages.
        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC-2:0], din[i]};
            end
        end

        assign sync_lvl = sync_q[SYNC-1];

        // Persistence filter: fc counts consecutive cycles of disagreement;
        // any agreement restarts the count, so short glitches are dropped.
        always_ff @(posedge clk) begin
            if (rst) begin
                lvl <= 1'b0;
                fc  <= '0;
            end else if (sync_lvl == lvl) begin
                fc <= '0;
            end else if (fc == FC_LAST) begin
                lvl <= sync_lvl;
                fc  <= '0;
            end else begin
                fc <= fc + 1'b1;
            end
        end

        // Pulses come from comparing lvl with its delayed copy, so they appear
        // the cycle after lvl changes.
        always_ff @(posedge clk) begin
            if (rst) begin
                lvl_d <= 1'b0;
                pos_q <= 1'b0;
                neg_q <= 1'b0;
            end else begin
                lvl_d <= lvl;
                pos_q <= lvl & ~lvl_d;
                neg_q <= ~lvl & lvl_d;
            end
        end

        // Combinational so a mode change affects evt in the same cycle.
        assign evt_c = (pos_q & mode[0]) | (neg_q & mode[1]);

        // A new event has priority over a clear issued in the same cycle.
        always_ff @(posedge clk) begin
            if (rst) begin
                flag_q <= 1'b0;
            end else if (evt_c) begin
                flag_q <= 1'b1;
            end else if (clr[i]) begin
                flag_q <= 1'b0;
            end
        end

        assign pos_edge[i] = pos_q;
        assign neg_edge[i] = neg_q;
        assign evt[i]      = evt_c;
        assign flag[i]     = flag_q;

`ifdef EDGE_CNT_EN
        logic [CNT_W-1:0] cnt_q;

        // Clear together with an event restarts the count at one.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
            end else if (clr[i]) begin
                cnt_q <= evt_c ? CNT_W'(1) : '0;
            end else if (evt_c && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign cnt[i*CNT_W +: CNT_W] = cnt_q;
`else
        assign cnt[i*CNT_W +: CNT_W] = '0;
`endif

    end : g_ch

endmodule

// File: tb/tb_edge_detect_mc.sv
module tb_edge_detect_mc;

    localparam int CH    = 4;
    localparam int SYNC  = 2;
    localparam int FILT  = 3;
    localparam int CNT_W = 8;

`ifdef EDGE_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic                clk;
    logic                rst;
    logic [CH-1:0]       din;
    logic [1:0]          mode;
    logic [CH-1:0]       clr;
    logic [CH-1:0]       pos_edge;
    logic [CH-1:0]       neg_edge;
    logic [CH-1:0]       evt;
    logic [CH-1:0]       flag;
    logic [CH*CNT_W-1:0] cnt;

    int n_cmp;
    int n_err;

    edge_detect_mc #(
        .CH(CH), .SYNC(SYNC), .FILT(FILT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .mode(mode), .clr(clr),
        .pos_edge(pos_edge), .neg_edge(neg_edge), .evt(evt),
        .flag(flag), .cnt(cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs are driven and outputs
    // sampled here, 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CNT_W-1:0] exp_cnt(input int v);
        return CNT_ON ? CNT_W'(v) : '0;
    endfunction

    // Three reset cycles, then ch0 rises right at release: the pulse must
    // appear only after the sixth edge (SYNC + FILT + 1).
    task automatic test_reset();
        rst  = 1'b1;
        din  = '0;
        mode = 2'b01;
        clr  = '0;
        repeat (3) tick();
        n_cmp++; if (pos_edge !== 4'h0) begin n_err++; $display("FAIL reset_pos got %h exp 0", pos_edge); end
        n_cmp++; if (neg_edge !== 4'h0) begin n_err++; $display("FAIL reset_neg got %h exp 0", neg_edge); end
        n_cmp++; if (evt !== 4'h0) begin n_err++; $display("FAIL reset_evt got %h exp 0", evt); end
        n_cmp++; if (flag !== 4'h0) begin n_err++; $display("FAIL reset_flag got %h exp 0", flag); end
        n_cmp++; if (cnt !== '0) begin n_err++; $display("FAIL reset_cnt got %h exp 0", cnt); end
        rst    = 1'b0;
        din[0] = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            tick();
            n_cmp++;
            if (pos_edge[0] !== (n == 6)) begin
                n_err++; $display("FAIL latency_pos0 edge %0d got %b exp %b", n, pos_edge[0], (n == 6));
            end
            n_cmp++;
            if (evt[0] !== (n == 6)) begin
                n_err++; $display("FAIL latency_evt0 edge %0d got %b exp %b", n, evt[0], (n == 6));
            end
        end
        n_cmp++; if (flag[0] !== 1'b1) begin n_err++; $display("FAIL flag0 got %b exp 1", flag[0]); end
        n_cmp++; if (cnt[0 +: CNT_W] !== exp_cnt(1)) begin n_err++; $display("FAIL cnt0 got %0d exp %0d", cnt[0 +: CNT_W], exp_cnt(1)); end
    endtask

    // Two-cycle glitch on ch1 is rejected; a three-cycle pulse passes as
    // one rising pulse (edge 6) and one falling pulse (edge 9).
    task automatic test_filter();
        mode   = 2'b01;
        din[1] = 1'b1;
        repeat (2) tick();
        din[1] = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            n_cmp++;
            if ({pos_edge[1], neg_edge[1], evt[1]} !== 3'b000) begin
                n_err++; $display("FAIL glitch_ch1 cycle %0d got %b exp 000", n, {pos_edge[1], neg_edge[1], evt[1]});
            end
        end
        din[1] = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            tick();
            if (n == 3) din[1] = 1'b0;
            n_cmp++;
            if ({pos_edge[1], neg_edge[1]} !== {(n == 6), (n == 9)}) begin
                n_err++; $display("FAIL pulse3_ch1 edge %0d got %b exp %b", n, {pos_edge[1], neg_edge[1]}, {(n == 6), (n == 9)});
            end
        end
    endtask

    // Falling-only mode: both raw pulses appear, evt only with the fall.
    task automatic test_mode_falling();
        mode   = 2'b10;
        din[2] = 1'b1;
        for (int n = 1; n <= 22; n++) begin
            tick();
            if (n == 10) din[2] = 1'b0;
            n_cmp++;
            if ({pos_edge[2], neg_edge[2], evt[2]} !== {(n == 6), (n == 16), (n == 16)}) begin
                n_err++; $display("FAIL falling_ch2 edge %0d got %b exp %b", n, {pos_edge[2], neg_edge[2], evt[2]}, {(n == 6), (n == 16), (n == 16)});
            end
        end
        n_cmp++; if (flag[2] !== 1'b1) begin n_err++; $display("FAIL flag2 got %b exp 1", flag[2]); end
        n_cmp++; if (cnt[2*CNT_W +: CNT_W] !== exp_cnt(1)) begin n_err++; $display("FAIL cnt2 got %0d exp %0d", cnt[2*CNT_W +: CNT_W], exp_cnt(1)); end
    endtask

    // 300 events on ch3 saturate the counter; clear with a coincident event
    // leaves count 1 and flag set; a lone clear empties both.
    task automatic test_saturation();
        mode = 2'b11;
        for (int t = 0; t < 300; t++) begin
            din[3] = ~din[3];
            repeat (10) tick();
        end
        repeat (4) tick();
        n_cmp++; if (cnt[3*CNT_W +: CNT_W] !== exp_cnt(255)) begin n_err++; $display("FAIL sat_cnt3 got %0d exp %0d", cnt[3*CNT_W +: CNT_W], exp_cnt(255)); end
        n_cmp++; if (flag[3] !== 1'b1) begin n_err++; $display("FAIL sat_flag3 got %b exp 1", flag[3]); end
        din[3] = 1'b1;
        repeat (6) tick();
        n_cmp++; if (evt[3] !== 1'b1) begin n_err++; $display("FAIL clr_evt3 got %b exp 1", evt[3]); end
        clr[3] = 1'b1;
        tick();
        clr[3] = 1'b0;
        n_cmp++; if (cnt[3*CNT_W +: CNT_W] !== exp_cnt(1)) begin n_err++; $display("FAIL clr_evt_cnt3 got %0d exp %0d", cnt[3*CNT_W +: CNT_W], exp_cnt(1)); end
        n_cmp++; if (flag[3] !== 1'b1) begin n_err++; $display("FAIL clr_evt_flag3 got %b exp 1", flag[3]); end
        clr[3] = 1'b1;
        tick();
        clr[3] = 1'b0;
        n_cmp++; if (cnt[3*CNT_W +: CNT_W] !== exp_cnt(0)) begin n_err++; $display("FAIL clr_cnt3 got %0d exp %0d", cnt[3*CNT_W +: CNT_W], exp_cnt(0)); end
        n_cmp++; if (flag[3] !== 1'b0) begin n_err++; $display("FAIL clr_flag3 got %b exp 0", flag[3]); end
    endtask

    // All channels high through reset release report together; a reset
    // during ch0's falling filter leaves that transition unreported.
    task automatic test_reset_release();
        rst  = 1'b1;
        din  = 4'hF;
        mode = 2'b01;
        clr  = '0;
        repeat (3) tick();
        n_cmp++; if (flag !== 4'h0) begin n_err++; $display("FAIL rr_flag got %h exp 0", flag); end
        rst = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            tick();
            n_cmp++;
            if (pos_edge !== ((n == 6) ? 4'hF : 4'h0)) begin
                n_err++; $display("FAIL rr_pos edge %0d got %h exp %h", n, pos_edge, ((n == 6) ? 4'hF : 4'h0));
            end
        end
        din[0] = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            n_cmp++;
            if ({pos_edge[0], neg_edge[0]} !== 2'b00) begin
                n_err++; $display("FAIL midrst_ch0 cycle %0d got %b exp 00", n, {pos_edge[0], neg_edge[0]});
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        din   = '0;
        mode  = 2'b00;
        clr   = '0;
        test_reset();
        test_filter();
        test_mode_falling();
        test_saturation();
        test_reset_release();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
